// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_ctrl_pkg
//  Purpose  : Shared types and default widths for the count_enable_ctrl block.
//  Contents : ctrl_state_e  - FSM state encoding (IDLE/RUN/DONE, 2'b11 illegal)
//             CNT_W_DEF     - default counter / limit width
//             PRESCALE_W_DEF- default prescale width
//  Revision : 1.0  initial release
// ============================================================================
package count_ctrl_pkg;

  localparam int CNT_W_DEF      = 4;
  localparam int PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : btn_sync_edge
//  Purpose  : Synchronises one raw asynchronous push-button and emits a
//             single-cycle registered pulse on its rising edge.
//  Ports    : clock - system clock
//             reset - synchronous active-high reset, clears every flop
//             raw   - raw asynchronous button level, active high
//             evt   - one-cycle pulse, SYNC_STAGES+1 cycles after raw is
//                     first sampled high; a held level yields one pulse
//  Revision : 1.0  initial release
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   evt_q;

  // Synchroniser chain, then an edge detector on its last stage. The pulse
  // itself is registered so the FSM sees a glitch-free, flop-driven event.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
      evt_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign evt = evt_q;

endmodule
`default_nettype wire

// File: rtl/count_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : count_enable_ctrl
//  Purpose  : Produces count_enable for a CNT_W-bit sync_counter. Buttons are
//             synchronised and edge-detected, enables are paced by a
//             programmable prescaler, and the counter value fed back on
//             count_q stops the run automatically at a programmed limit.
//  Ports    : clock, reset          - clock, synchronous active-high reset
//             start_btn/stop_btn/
//             step_btn              - raw asynchronous button inputs
//             prescale              - enable period minus 1 while running
//             limit, auto_stop      - auto-stop value and its enable
//             count_q               - current counter value (feedback)
//             count_enable          - registered enable to the counter
//             running               - high while in RUN
//             limit_hit             - one-cycle pulse on entering DONE
//             state                 - current FSM state (debug)
//  Revision : 1.0  initial release
// ============================================================================
module count_enable_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PRESCALE_W  = PRESCALE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic                  stop_btn,
  input  logic                  step_btn,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CNT_W-1:0]      limit,
  input  logic                  auto_stop,
  input  logic [CNT_W-1:0]      count_q,
  output logic                  count_enable,
  output logic                  running,
  output logic                  limit_hit,
  output logic [1:0]            state
);

  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic start_evt;
  logic stop_evt;
  logic step_evt;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clock (clock),
    .reset (reset),
    .raw   (start_btn),
    .evt   (start_evt)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clock (clock),
    .reset (reset),
    .raw   (stop_btn),
    .evt   (stop_evt)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clock (clock),
    .reset (reset),
    .raw   (step_btn),
    .evt   (step_evt)
  );

  ctrl_state_e           state_q,     state_d;
  logic [PRESCALE_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic                  enable_q,    enable_d;
  logic                  limit_hit_q, limit_hit_d;

  logic [CNT_W-1:0]      cnt_plus1;
  logic                  hit;

  // The enable currently on the wire will advance the counter at this edge;
  // if that advance lands on limit, this is the last enable of the run.
  assign cnt_plus1 = count_q + CNT_ONE;
  assign hit       = auto_stop & enable_q & (cnt_plus1 == limit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      enable_q    <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      enable_q    <= enable_d;
      limit_hit_q <= limit_hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    enable_d    = 1'b0;
    limit_hit_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // stop outranks start, start outranks step
        if (stop_evt) begin
          state_d = IDLE;
        end else if (start_evt) begin
          state_d   = RUN;
          pre_cnt_d = '0;
        end else if (step_evt) begin
          enable_d = 1'b1;
        end
      end

      RUN: begin
        if (stop_evt) begin
          // stop also beats a coincident limit hit: no limit_hit pulse
          state_d = IDLE;
        end else if (hit) begin
          state_d     = DONE;
          limit_hit_d = 1'b1;
        end else if (pre_cnt_q >= prescale) begin
          // >= so that lowering prescale mid-run fires immediately
          pre_cnt_d = '0;
          enable_d  = 1'b1;
        end else begin
          pre_cnt_d = pre_cnt_q + PRE_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign count_enable = enable_q;
  assign running      = (state_q == RUN);
  assign limit_hit    = limit_hit_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_enable_ctrl
//  Purpose  : Self-checking bench for count_enable_ctrl running closed loop
//             against a behavioural 4-bit counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_enable_ctrl;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_STEP  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, stop_btn, step_btn;
  logic [7:0] prescale;
  logic [3:0] limit;
  logic       auto_stop;
  logic [3:0] q;
  logic       count_enable, running, limit_hit;
  logic [1:0] state;

  logic       ld;
  logic [3:0] ld_val;

  int n_checks = 0;
  int n_errors = 0;
  int en_total = 0;
  int hit_total = 0;

  always #5 clk = ~clk;

  count_enable_ctrl #(.CNT_W(4), .PRESCALE_W(8), .SYNC_STAGES(2)) dut (
    .clock        (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .step_btn     (step_btn),
    .prescale     (prescale),
    .limit        (limit),
    .auto_stop    (auto_stop),
    .count_q      (q),
    .count_enable (count_enable),
    .running      (running),
    .limit_hit    (limit_hit),
    .state        (state)
  );

  // Behavioural sync_counter; independent of the controller's reset.
  always_ff @(posedge clk) begin
    if (ld)                q <= ld_val;
    else if (count_enable) q <= q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (count_enable === 1'b1) en_total  <= en_total + 1;
    if (limit_hit === 1'b1)    hit_total <= hit_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_q(input logic [3:0] v);
    ld     = 1'b1;
    ld_val = v;
    tick();
    ld     = 1'b0;
  endtask

  task automatic press(input int which);
    case (which)
      BTN_START: start_btn = 1'b1;
      BTN_STOP:  stop_btn  = 1'b1;
      default:   step_btn  = 1'b1;
    endcase
    tick();
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    step_btn  = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(name, state, s);
  endtask

  typedef struct {
    logic [7:0] prescale;
    logic [3:0] limit;
    logic [3:0] q0;
    int         exp_en;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int e0, h0;
    logic [3:0] qh;

    reset = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
    prescale = 8'd0; limit = 4'd0; auto_stop = 1'b0;
    ld = 1'b1; ld_val = 4'd0;
    tick();
    ld = 1'b0;

    // auto-stop runs: {prescale, limit, start Q, enables, final Q}
    vecs[0] = '{8'd0, 4'd5,  4'd0,  5,  4'd5};
    vecs[1] = '{8'd3, 4'd3,  4'd0,  3,  4'd3};
    vecs[2] = '{8'd0, 4'd0,  4'd12, 4,  4'd0};   // stop on wrap
    vecs[3] = '{8'd0, 4'd7,  4'd7,  16, 4'd7};   // start on limit: full lap
    vecs[4] = '{8'd2, 4'd15, 4'd10, 5,  4'd15};

    // reset state
    do_reset();
    chk("rst count_enable", count_enable, 1'b0);
    chk("rst state", state, 2'b00);
    chk("rst running", running, 1'b0);
    chk("rst limit_hit", limit_hit, 1'b0);

    // table-driven auto-stop runs
    for (int i = 0; i < 5; i++) begin
      do_reset();
      load_q(vecs[i].q0);
      prescale  = vecs[i].prescale;
      limit     = vecs[i].limit;
      auto_stop = 1'b1;
      e0 = en_total;
      h0 = hit_total;
      press(BTN_START);
      wait_state(2'b10, 200, $sformatf("vec%0d reach DONE", i));
      repeat (5) tick();
      chk($sformatf("vec%0d enables", i), en_total - e0, vecs[i].exp_en);
      chk($sformatf("vec%0d final Q", i), q, vecs[i].exp_q);
      chk($sformatf("vec%0d state", i), state, 2'b10);
      chk($sformatf("vec%0d limit_hit pulses", i), hit_total - h0, 1);
      chk($sformatf("vec%0d running", i), running, 1'b0);
    end

    // step from DONE (Q=5), then a restart with limit=5 laps to 5 again
    do_reset();
    load_q(4'd0);
    prescale = 8'd0; limit = 4'd5; auto_stop = 1'b1;
    press(BTN_START);
    wait_state(2'b10, 100, "pre-step reach DONE");
    repeat (3) tick();
    e0 = en_total;
    press(BTN_STEP);
    repeat (8) tick();
    chk("step enables", en_total - e0, 1);
    chk("step Q", q, 4'd6);
    chk("step state", state, 2'b10);
    e0 = en_total;
    h0 = hit_total;
    press(BTN_START);
    wait_state(2'b01, 20, "restart reach RUN");
    wait_state(2'b10, 100, "restart reach DONE");
    repeat (5) tick();
    chk("restart enables", en_total - e0, 15);
    chk("restart Q", q, 4'd5);
    chk("restart limit_hit pulses", hit_total - h0, 1);

    // free run, prescale=3: one enable every 4 cycles, wrap 15->0
    do_reset();
    load_q(4'd0);
    prescale = 8'd3; auto_stop = 1'b0; limit = 4'd2;
    h0 = hit_total;
    press(BTN_START);
    wait_state(2'b01, 20, "free run reach RUN");
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("prescale3 enable cycle %0d", k), count_enable, (k % 4 == 0));
    end
    chk("free run Q before wrap", q, 4'd15);
    tick();
    chk("free run Q wrapped", q, 4'd0);
    chk("free run no limit_hit", hit_total - h0, 0);
    press(BTN_STOP);
    wait_state(2'b00, 20, "free run stop to IDLE");

    // reset mid-RUN with prescale=0
    do_reset();
    load_q(4'd0);
    prescale = 8'd0; auto_stop = 1'b0;
    press(BTN_START);
    wait_state(2'b01, 20, "midrun reach RUN");
    repeat (3) tick();
    chk("midrun enable high", count_enable, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun rst count_enable", count_enable, 1'b0);
    chk("midrun rst state", state, 2'b00);
    chk("midrun rst running", running, 1'b0);
    qh = q;
    repeat (4) tick();
    chk("midrun Q holds", q, qh);

    // stop and start together in IDLE: stop wins
    do_reset();
    e0 = en_total;
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    tick();
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    repeat (10) tick();
    chk("coincident start/stop state", state, 2'b00);
    chk("coincident start/stop enables", en_total - e0, 0);

    // stop arriving in the very cycle the first fire is due (prescale=3)
    do_reset();
    prescale = 8'd3; auto_stop = 1'b0;
    e0 = en_total;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    repeat (3) tick();
    stop_btn = 1'b1;
    tick();
    stop_btn = 1'b0;
    chk("stop-on-fire in RUN", running, 1'b1);
    repeat (12) tick();
    chk("stop-on-fire enables", en_total - e0, 0);
    chk("stop-on-fire state", state, 2'b00);

    // held step button yields one enable
    do_reset();
    e0 = en_total;
    step_btn = 1'b1;
    repeat (20) tick();
    step_btn = 1'b0;
    repeat (5) tick();
    chk("held step enables", en_total - e0, 1);
    chk("held step state", state, 2'b00);

    // illegal state recovers to IDLE
    @(negedge clk);
    force dut.state_q = count_ctrl_pkg::ctrl_state_e'(2'b11);
    #1;
    release dut.state_q;
    tick();
    chk("illegal state to IDLE", state, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
